// File: rtl/rf_pkg.sv
// Shared types for the rf_32 write-back queue (rf_wb_queue).
// Optional read-side forwarding is enabled by defining RF_WB_BYPASS_EN.
package rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push / single-pop circular buffer of register writes.
// Entries are presented oldest-first so callers can rank matches by age.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_a,
    input  wb_entry_t                  entry_a,
    input  logic                       push_b,
    input  wb_entry_t                  entry_b,
    input  logic                       pop,
    output wb_entry_t                  entries [DEPTH],
    output logic [DEPTH-1:0]           valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_b;
    wb_entry_t        mem [DEPTH];

    // A lone load request takes the first free slot, so it never leaves a hole.
    assign wr_ptr_b = push_a ? wr_ptr + PTR_W'(1) : wr_ptr;

    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= entry_a;
        if (push_b) mem[wr_ptr_b] <= entry_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rd_ptr + PTR_W'(i)];
            valid[i]   = (CNT_W'(i) < count);
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Write-back queue in front of rf_32's single write port, with read-side hazard/forwarding.
// Define RF_WB_BYPASS_EN to forward queued data instead of raising hazard.
module rf_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [ADDR_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_rd,
    input  logic [DATA_W-1:0]       ld_data,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       rf_rd,
    output logic [DATA_W-1:0]       rf_write_data,
    output logic                    rf_we,
    input  logic [ADDR_W-1:0]       rs,
    input  logic [ADDR_W-1:0]       rt,
    input  logic [DATA_W-1:0]       rf_out_a,
    input  logic [DATA_W-1:0]       rf_out_b,
    output logic [DATA_W-1:0]       out_a,
    output logic [DATA_W-1:0]       out_b,
    output logic                    hazard,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count
);

    import rf_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             alu_take;
    logic             ld_take;
    logic             push_a;
    logic             push_b;
    wb_entry_t        entry_a;
    wb_entry_t        entry_b;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             hit_a;
    logic             hit_b;

    assign alu_take = alu_valid && (alu_rd != ZERO_REG);
    assign ld_take  = ld_valid && (ld_rd != ZERO_REG);
    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign push_a   = alu_take && in_ready;
    assign push_b   = ld_take && in_ready;
    assign entry_a  = '{rd: alu_rd, data: alu_data};
    assign entry_b  = '{rd: ld_rd, data: ld_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_a  (push_a),
        .entry_a (entry_a),
        .push_b  (push_b),
        .entry_b (entry_b),
        .pop     (rf_we),
        .entries (entries),
        .valid   (valid),
        .count   (count)
    );

    // Held low during reset so the head is neither written nor popped at the reset edge.
    assign rf_we         = (count != '0) && !rst;
    assign rf_rd         = rf_we ? entries[0].rd : '0;
    assign rf_write_data = rf_we ? entries[0].data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if ((alu_take || ld_take) && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    // Entries are oldest-first, so the last match in the scan is the youngest.
    always_comb begin
        out_a  = rf_out_a;
        out_b  = rf_out_b;
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].rd == rs) begin
                hit_a = 1'b1;
`ifdef RF_WB_BYPASS_EN
                out_a = entries[i].data;
`endif
            end
            if (valid[i] && entries[i].rd == rt) begin
                hit_b = 1'b1;
`ifdef RF_WB_BYPASS_EN
                out_b = entries[i].data;
`endif
            end
        end
`ifndef RF_WB_BYPASS_EN
        hazard = (hit_a && rs != ZERO_REG) || (hit_b && rt != ZERO_REG);
`else
        hazard = 1'b0;
`endif
        if (rs == ZERO_REG) out_a = '0;
        if (rt == ZERO_REG) out_b = '0;
    end

endmodule
